axi_ar_arbiter: RTL and testbench

//  Round-robin arbiter for the AXI read-address (AR) channel between NUM_MASTERS masters.

---
 rtl/axi_ar_arbiter.sv | 136 +++++++++++++
 tb/tb_axi_ar_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_arbiter.sv
// Round-robin arbiter for the AXI read-address channel. A grant is held from AR
// handshake until the burst's RLAST handshake, with a watchdog for stuck bursts.
module axi_ar_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MID_W       = 3,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] ARVALID_M,
  output logic [NUM_MASTERS-1:0] ARREADY_M,
  output logic                   ARVALID_S,
  input  logic                   ARREADY_S,
  input  logic                   RVALID_S,
  input  logic                   RREADY_S,
  input  logic                   RLAST_S,
  output logic [NUM_MASTERS-1:0] GRANT,
  output logic [MID_W-1:0]       GRANT_ID,
  output logic                   BUSY,
  output logic                   TIMEOUT_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [MID_W-1:0]       ptr_reg, ptr_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [MID_W-1:0]       grant_id_reg, grant_id_next;
  logic [CNT_W-1:0]       wd_cnt_reg, wd_cnt_next;
  logic                   timeout_err_reg, timeout_err_next;

  logic                   pick_found;
  logic [MID_W-1:0]       pick_id;
  logic [MID_W:0]         idx_w;
  logic                   ar_hs;
  logic                   r_last_hs;
  logic                   wd_expired;
  logic [MID_W-1:0]       ptr_adv;

  // Scan requesters starting at the pointer; idx_w is one bit wider so ptr+i never overflows
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx_w      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx_w = {1'b0, ptr_reg} + (MID_W+1)'(i);
      if (idx_w >= (MID_W+1)'(NUM_MASTERS))
        idx_w = idx_w - (MID_W+1)'(NUM_MASTERS);
      if (!pick_found && |(ARVALID_M & (NUM_MASTERS'(1) << idx_w))) begin
        pick_found = 1'b1;
        pick_id    = idx_w[MID_W-1:0];
      end
    end
  end

  assign ARVALID_S  = (state_reg == ST_ADDR) && |(ARVALID_M & grant_reg);
  assign ar_hs      = ARVALID_S && ARREADY_S;
  assign r_last_hs  = RVALID_S && RREADY_S && RLAST_S;
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign ptr_adv    = (grant_id_reg == MID_W'(NUM_MASTERS - 1)) ? '0 : grant_id_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_arready
      assign ARREADY_M[gi] = (state_reg == ST_ADDR) && grant_reg[gi] && ARREADY_S;
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    grant_next       = grant_reg;
    grant_id_next    = grant_id_reg;
    wd_cnt_next      = wd_cnt_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_next    = NUM_MASTERS'(1) << pick_id;
          grant_id_next = pick_id;
          state_next    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          state_next  = ST_DATA;
          wd_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (wd_cnt_reg != {CNT_W{1'b1}})
          wd_cnt_next = wd_cnt_reg + 1'b1;
        // A real RLAST handshake takes precedence over a watchdog expiry in the same cycle
        if (r_last_hs || wd_expired) begin
          state_next       = ST_IDLE;
          grant_next       = '0;
          grant_id_next    = '0;
          ptr_next         = ptr_adv;
          timeout_err_next = !r_last_hs;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        grant_next    = '0;
        grant_id_next = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      grant_reg       <= '0;
      grant_id_reg    <= '0;
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      grant_reg       <= grant_next;
      grant_id_reg    <= grant_id_next;
      wd_cnt_reg      <= wd_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign GRANT       = grant_reg;
  assign GRANT_ID    = grant_id_reg;
  assign BUSY        = (state_reg != ST_IDLE);
  assign TIMEOUT_ERR = timeout_err_reg;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Bench for axi_ar_arbiter: directed stimulus with a scoreboard monitor that checks
// every new grant and every release against queued expectations.
module tb_axi_ar_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [1:0] ARVALID_M;
  logic [1:0] ARREADY_M;
  logic       ARVALID_S;
  logic       ARREADY_S;
  logic       RVALID_S;
  logic       RREADY_S;
  logic       RLAST_S;
  logic [1:0] GRANT;
  logic [2:0] GRANT_ID;
  logic       BUSY;
  logic       TIMEOUT_ERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_grant_q[$];
  logic       exp_terr_q[$];
  bit         mon_en = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_ar_arbiter #(
    .NUM_MASTERS(2),
    .MID_W      (3),
    .TIMEOUT    (16),
    .CNT_W      (5)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .ARVALID_M  (ARVALID_M),
    .ARREADY_M  (ARREADY_M),
    .ARVALID_S  (ARVALID_S),
    .ARREADY_S  (ARREADY_S),
    .RVALID_S   (RVALID_S),
    .RREADY_S   (RREADY_S),
    .RLAST_S    (RLAST_S),
    .GRANT      (GRANT),
    .GRANT_ID   (GRANT_ID),
    .BUSY       (BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  // Monitor: pops expectations on each 0->grant transition and each release
  initial begin
    logic [1:0] pg;
    logic       pb;
    logic [1:0] eg;
    logic       et;
    pg = '0;
    pb = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge ACLK);
      if (GRANT != 2'b00)
        chk("grant_id_match", 32'(GRANT), 32'(2'b01 << GRANT_ID));
      if (pg == 2'b00 && GRANT != 2'b00) begin
        if (exp_grant_q.size() == 0) begin
          chk("grant_unexpected", 32'(GRANT), 32'd0);
        end else begin
          eg = exp_grant_q.pop_front();
          chk("sb_grant", 32'(GRANT), 32'(eg));
          $display("[TB] grant 0x%0h id %0d (expected 0x%0h)", GRANT, GRANT_ID, eg);
        end
      end
      if (pb && !BUSY) begin
        if (exp_terr_q.size() == 0) begin
          chk("release_unexpected", 32'(BUSY), 32'd1);
        end else begin
          et = exp_terr_q.pop_front();
          chk("sb_release_terr", 32'(TIMEOUT_ERR), 32'(et));
          $display("[TB] release timeout_err=%0b (expected %0b)", TIMEOUT_ERR, et);
        end
      end
      pg = GRANT;
      pb = BUSY;
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] e;
    ARESETn   = 1'b0;
    ARVALID_M = 2'b11;
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RREADY_S  = 1'b0;
    RLAST_S   = 1'b0;

    // Reset held with both masters requesting
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_grant", 32'(GRANT), 32'd0);
      chk("rst_arvalid_s", 32'(ARVALID_S), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_arready_m", 32'(ARREADY_M), 32'd0);
    end
    chk("rst_grant_id", 32'(GRANT_ID), 32'd0);
    chk("rst_terr", 32'(TIMEOUT_ERR), 32'd0);
    mon_en    = 1'b1;
    ARVALID_M = 2'b00;
    ARESETn   = 1'b1;
    step();

    // Single M0 request, AR handshake at cycle 3, 4-beat burst
    ARVALID_M = 2'b01;
    exp_grant_q.push_back(2'b01);
    step();
    chk("t2_grant", 32'(GRANT), 32'd1);
    chk("t2_arvalid_s", 32'(ARVALID_S), 32'd1);
    chk("t2_arready_m_wait", 32'(ARREADY_M), 32'd0);
    step();
    chk("t2_grant_hold", 32'(GRANT), 32'd1);
    step();
    ARREADY_S = 1'b1;
    #1;
    chk("t2_arready_m", 32'(ARREADY_M), 32'h1);
    step();
    ARREADY_S = 1'b0;
    ARVALID_M = 2'b00;
    chk("t2_busy_data", 32'(BUSY), 32'd1);
    chk("t2_arvalid_s_data", 32'(ARVALID_S), 32'd0);
    for (int b = 1; b <= 4; b++) begin
      RVALID_S = 1'b1;
      RREADY_S = 1'b1;
      RLAST_S  = (b == 4);
      if (b == 4) exp_terr_q.push_back(1'b0);
      step();
      chk("t2_grant_beat", 32'(GRANT), (b == 4) ? 32'd0 : 32'd1);
    end
    RVALID_S = 1'b0;
    RREADY_S = 1'b0;
    RLAST_S  = 1'b0;
    chk("t2_busy_done", 32'(BUSY), 32'd0);

    // Back-to-back single-beat bursts with both masters requesting
    ARESETn = 1'b0;
    step();
    ARESETn   = 1'b1;
    ARVALID_M = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_grant_q.push_back(e);
      step();
      chk("t3_grant", 32'(GRANT), 32'(e));
      ARREADY_S = 1'b1;
      #1;
      chk("t3_arready_m", 32'(ARREADY_M), 32'(e));
      chk("t3_arvalid_s", 32'(ARVALID_S), 32'd1);
      step();
      ARREADY_S = 1'b0;
      exp_terr_q.push_back(1'b0);
      RVALID_S = 1'b1;
      RREADY_S = 1'b1;
      RLAST_S  = 1'b1;
      step();
      RVALID_S = 1'b0;
      RREADY_S = 1'b0;
      RLAST_S  = 1'b0;
      chk("t3_gap_grant", 32'(GRANT), 32'd0);
      chk("t3_gap_busy", 32'(BUSY), 32'd0);
    end
    ARVALID_M = 2'b00;

    // Watchdog: M1 granted, R never arrives
    ARVALID_M = 2'b10;
    exp_grant_q.push_back(2'b10);
    step();
    chk("t4_grant", 32'(GRANT), 32'h2);
    ARREADY_S = 1'b1;
    step();
    ARREADY_S = 1'b0;
    ARVALID_M = 2'b00;
    exp_terr_q.push_back(1'b1);
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("t4_terr", 32'(TIMEOUT_ERR), (n == 16) ? 32'd1 : 32'd0);
      if (n < 16) chk("t4_busy", 32'(BUSY), 32'd1);
    end
    chk("t4_busy_after", 32'(BUSY), 32'd0);
    step();
    chk("t4_terr_pulse", 32'(TIMEOUT_ERR), 32'd0);
    ARVALID_M = 2'b11;
    exp_grant_q.push_back(2'b01);
    step();
    chk("t4_next_grant", 32'(GRANT), 32'h1);

    // RLAST on the watchdog's final cycle; earlier non-last beats must not release
    ARREADY_S = 1'b1;
    step();
    ARREADY_S = 1'b0;
    ARVALID_M = 2'b00;
    for (int n = 1; n <= 15; n++) begin
      RVALID_S = 1'b1;
      RREADY_S = 1'b1;
      RLAST_S  = 1'b0;
      step();
      chk("t5_busy", 32'(BUSY), 32'd1);
      chk("t5_terr", 32'(TIMEOUT_ERR), 32'd0);
    end
    RLAST_S = 1'b1;
    exp_terr_q.push_back(1'b0);
    step();
    RVALID_S = 1'b0;
    RREADY_S = 1'b0;
    RLAST_S  = 1'b0;
    chk("t5_grant", 32'(GRANT), 32'd0);
    chk("t5_terr_rlast", 32'(TIMEOUT_ERR), 32'd0);
    chk("t5_busy_done", 32'(BUSY), 32'd0);

    // Reset during DATA with M1 granted; pointer must return to 0
    ARVALID_M = 2'b11;
    exp_grant_q.push_back(2'b10);
    step();
    chk("t6_grant", 32'(GRANT), 32'h2);
    ARREADY_S = 1'b1;
    step();
    ARREADY_S = 1'b0;
    chk("t6_busy", 32'(BUSY), 32'd1);
    ARESETn = 1'b0;
    exp_terr_q.push_back(1'b0);
    step();
    chk("t6_grant_rst", 32'(GRANT), 32'd0);
    chk("t6_busy_rst", 32'(BUSY), 32'd0);
    chk("t6_id_rst", 32'(GRANT_ID), 32'd0);
    ARESETn = 1'b1;
    exp_grant_q.push_back(2'b01);
    step();
    chk("t6_grant_after", 32'(GRANT), 32'h1);
    chk("t6_id_after", 32'(GRANT_ID), 32'd0);

    ARVALID_M = 2'b00;
    ARESETn   = 1'b0;
    exp_terr_q.push_back(1'b0);
    step();
    step();
    step();
    chk("sb_grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
    chk("sb_terr_q_empty", 32'(exp_terr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
